// File: rtl/vga_cfg_master_pkg.sv
// vga_cfg_master_pkg: shared config-bus widths, addresses and resolution codes
// used by the VGA configuration master and its neighbours.
package vga_cfg_master_pkg;

    localparam int VGA_CONFIG_WIDTH = 8;
    localparam logic [7:0] VGA_ADDR_CONFIG = 8'h01;

    typedef enum logic [1:0] {
        R6X4  = 2'b00,
        R8X6  = 2'b01,
        R10X7 = 2'b10,
        R_ILL = 2'b11
    } res_t;

    function automatic logic res_legal(input logic [1:0] r);
        return r != R_ILL;
    endfunction

endpackage

// File: rtl/vga_cfg_timer.sv
// vga_cfg_timer: acknowledge timeout counter; held at zero while clr is high,
// counts otherwise and flags the last cycle of the window.
module vga_cfg_timer
    import vga_cfg_master_pkg::*;
#(
    parameter int TIMEOUT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tc
);

    localparam int TW = $clog2(TIMEOUT);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= clr ? '0 : cnt + 1'b1;
    end

    assign tc = cnt == TW'(TIMEOUT - 1);

endmodule

// File: rtl/vga_cfg_master.sv
// vga_cfg_master: programs the VGA resolution register over the config bus,
// with acknowledge timeout, bounded retry and a one-deep pending request.
module vga_cfg_master
    import vga_cfg_master_pkg::*;
#(
    parameter int                      CONFIG_WIDTH    = VGA_CONFIG_WIDTH,
    parameter logic [CONFIG_WIDTH-1:0] ADDR_VGA_CONFIG = CONFIG_WIDTH'(VGA_ADDR_CONFIG),
    parameter int                      TIMEOUT         = 8,
    parameter int                      MAX_RETRY       = 2,
    parameter logic [1:0]              BOOT_RES        = 2'b00
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req,
    input  logic [1:0]              res_sel,
    input  logic                    c_rdy,
    output logic                    c_valid,
    output logic [CONFIG_WIDTH-1:0] c_addr,
    output logic [CONFIG_WIDTH-1:0] c_data,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [1:0]              cur_res
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, FIN} state_t;

    localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

    state_t        state, state_d;
    logic [1:0]    sel, sel_d, pend_sel, pend_sel_d, cur_res_d, start_sel;
    logic          pend_vld, pend_vld_d, boot, ok, ok_d;
    logic          start, done_d, error_d, tc;
    logic [RW-1:0] retry, retry_d;

    vga_cfg_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (state != WAIT),
        .tc   (tc)
    );

    always_comb begin
        state_d    = state;
        sel_d      = sel;
        retry_d    = retry;
        ok_d       = ok;
        pend_vld_d = pend_vld;
        pend_sel_d = pend_sel;
        cur_res_d  = cur_res;
        done_d     = 1'b0;
        error_d    = 1'b0;
        start      = req || boot || pend_vld;
        start_sel  = req ? res_sel : boot ? BOOT_RES : pend_sel;
        case (state)
            IDLE: if (start) begin
                pend_vld_d = 1'b0;
                if (res_legal(start_sel)) begin
                    sel_d   = start_sel;
                    state_d = SEND;
                end else begin
                    error_d = 1'b1;
                end
            end
            SEND: state_d = WAIT;
            WAIT: if (c_rdy) begin
                ok_d    = 1'b1;
                state_d = FIN;
            end else if (tc) begin
                if (retry < RETRY_LIM) begin
                    retry_d = retry + 1'b1;
                    state_d = SEND;
                end else begin
                    ok_d    = 1'b0;
                    state_d = FIN;
                end
            end
            FIN: begin
                done_d    = ok;
                error_d   = !ok;
                cur_res_d = ok ? sel : cur_res;
                retry_d   = '0;
                // an illegal pending select is left for IDLE to reject
                if (pend_vld && res_legal(pend_sel)) begin
                    sel_d      = pend_sel;
                    pend_vld_d = 1'b0;
                    state_d    = SEND;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (req && state != IDLE) begin
            pend_vld_d = 1'b1;
            pend_sel_d = res_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel      <= 2'b00;
            retry    <= '0;
            ok       <= 1'b0;
            pend_vld <= 1'b0;
            pend_sel <= 2'b00;
            boot     <= BOOT_RES != 2'b00;
            c_valid  <= 1'b0;
            c_addr   <= '0;
            c_data   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            cur_res  <= 2'b00;
        end else begin
            state    <= state_d;
            sel      <= sel_d;
            retry    <= retry_d;
            ok       <= ok_d;
            pend_vld <= pend_vld_d;
            pend_sel <= pend_sel_d;
            boot     <= 1'b0;
            c_valid  <= state_d == SEND;
            c_addr   <= state_d == SEND ? ADDR_VGA_CONFIG : '0;
            c_data   <= state_d == SEND ? CONFIG_WIDTH'(sel_d) : '0;
            busy     <= state_d != IDLE;
            done     <= done_d;
            error    <= error_d;
            cur_res  <= cur_res_d;
        end
    end

endmodule

// File: tb/tb_vga_cfg_master.sv
// tb_vga_cfg_master: randomized scenarios for the VGA config master, checked
// against event timings derived from the bus protocol rules.
module tb_vga_cfg_master;
    import vga_cfg_master_pkg::*;

    localparam int TO = 8;
    localparam int MR = 2;
    localparam int GAP = TO + 1;

    typedef struct {int t; logic [7:0] d; logic [7:0] a;} ev_t;
    typedef struct {int off; logic [1:0] s;} rq_t;

    logic       clk = 0, rst_n = 0, req = 0, c_rdy = 0;
    logic [1:0] res_sel = 0;
    logic       c_valid, busy, done, error;
    logic [7:0] c_addr, c_data;
    logic [1:0] cur_res;

    logic       rst_b = 0, c_rdy_b = 0, req_b = 0;
    logic [1:0] res_sel_b = 0;
    logic       c_valid_b, busy_b, done_b, error_b;
    logic [7:0] c_addr_b, c_data_b;
    logic [1:0] cur_res_b;

    int   cyc = 0, total = 0, bad = 0, busy_n = 0;
    logic [1:0] model_res = 2'b00;
    ev_t  vq[$];
    int   dq[$], eq[$];
    rq_t  rqs[$];

    vga_cfg_master #(.TIMEOUT(TO), .MAX_RETRY(MR)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .res_sel(res_sel), .c_rdy(c_rdy),
        .c_valid(c_valid), .c_addr(c_addr), .c_data(c_data), .busy(busy),
        .done(done), .error(error), .cur_res(cur_res)
    );

    vga_cfg_master #(.TIMEOUT(TO), .MAX_RETRY(MR), .BOOT_RES(2'b10)) dut_boot (
        .clk(clk), .rst_n(rst_b), .req(req_b), .res_sel(res_sel_b), .c_rdy(c_rdy_b),
        .c_valid(c_valid_b), .c_addr(c_addr_b), .c_data(c_data_b), .busy(busy_b),
        .done(done_b), .error(error_b), .cur_res(cur_res_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (c_valid) vq.push_back('{cyc, c_data, c_addr});
        if (done) dq.push_back(cyc);
        if (error) eq.push_back(cyc);
        if (busy) busy_n++;
    end

    // att = -1 never acks, -2 acks every send, else acks only the att-th send
    task automatic drive(input int att, input int j, input int budget, output int k);
        int target = -1;
        int n = 0;
        vq.delete(); dq.delete(); eq.delete(); busy_n = 0;
        k = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (i == 0) k = cyc;
            req = 0;
            foreach (rqs[q]) if (rqs[q].off == i) begin req = 1; res_sel = rqs[q].s; end
            c_rdy = cyc == target;
            if (c_valid) begin
                if (att == -2 || n == att) target = cyc + 1 + j;
                n++;
            end
        end
        req = 0;
        c_rdy = 0;
    endtask

    task automatic test_reset();
        total++; if (c_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin bad++; $display("FAIL reset_ctl: got v%b b%b d%b e%b want 0000", c_valid, busy, done, error); end
        total++; if (c_addr !== 8'h00 || c_data !== 8'h00) begin bad++; $display("FAIL reset_bus: got %h/%h want 00/00", c_addr, c_data); end
        total++; if (cur_res !== 2'b00) begin bad++; $display("FAIL reset_cur: got %b want 00", cur_res); end
        @(negedge clk); rst_n = 1;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0 || c_valid !== 1'b0) begin bad++; $display("FAIL no_boot: got b%b v%b want 00", busy, c_valid); end
    endtask

    task automatic test_single();
        int k, att, j, t_end;
        logic [1:0] s;
        for (int it = 0; it < 10; it++) begin
            s   = it == 0 ? 2'b01 : 2'($urandom_range(0, 2));
            att = it == 0 ? 0 : int'($urandom_range(0, MR));
            j   = it == 0 ? 0 : int'($urandom_range(0, TO - 1));
            rqs.delete(); rqs.push_back('{0, s});
            drive(att, j, 40, k);
            t_end = k + 1 + GAP * att + 3 + j;
            total++; if (vq.size() != att + 1) begin bad++; $display("FAIL single_sends: got %0d want %0d", vq.size(), att + 1); end
            foreach (vq[i]) begin
                total++; if (vq[i].t != k + 1 + GAP * i || vq[i].d !== {6'b0, s} || vq[i].a !== 8'h01) begin bad++; $display("FAIL single_send%0d: got t%0d %h/%h want t%0d 01/%h", i, vq[i].t - k, vq[i].a, vq[i].d, 1 + GAP * i, {6'b0, s}); end
            end
            total++; if (dq.size() != 1 || eq.size() != 0) begin bad++; $display("FAIL single_outcome: got done=%0d err=%0d want 1/0", dq.size(), eq.size()); end
            else begin
                total++; if (dq[0] != t_end) begin bad++; $display("FAIL single_done_time: got %0d want %0d", dq[0] - k, t_end - k); end
            end
            total++; if (busy_n != t_end - k - 1) begin bad++; $display("FAIL single_busy: got %0d want %0d", busy_n, t_end - k - 1); end
            total++; if (cur_res !== s) begin bad++; $display("FAIL single_cur: got %b want %b", cur_res, s); end
            model_res = s;
        end
    endtask

    task automatic test_timeout();
        int k, t_err;
        logic [1:0] s;
        for (int it = 0; it < 2; it++) begin
            s = model_res == 2'b10 ? 2'b00 : model_res + 2'b01;
            rqs.delete(); rqs.push_back('{0, s});
            drive(-1, 0, 40, k);
            t_err = k + 1 + GAP * MR + TO + 2;
            total++; if (vq.size() != MR + 1) begin bad++; $display("FAIL to_sends: got %0d want %0d", vq.size(), MR + 1); end
            foreach (vq[i]) begin
                total++; if (vq[i].t != k + 1 + GAP * i || vq[i].d !== {6'b0, s}) begin bad++; $display("FAIL to_send%0d: got t%0d d%h want t%0d d%h", i, vq[i].t - k, vq[i].d, 1 + GAP * i, {6'b0, s}); end
            end
            total++; if (eq.size() != 1 || dq.size() != 0) begin bad++; $display("FAIL to_outcome: got err=%0d done=%0d want 1/0", eq.size(), dq.size()); end
            else begin
                total++; if (eq[0] != t_err) begin bad++; $display("FAIL to_err_time: got %0d want %0d", eq[0] - k, t_err - k); end
            end
            total++; if (cur_res !== model_res || busy !== 1'b0) begin bad++; $display("FAIL to_cur: got %b busy%b want %b busy0", cur_res, busy, model_res); end
        end
    endtask

    task automatic test_illegal();
        int k;
        rqs.delete(); rqs.push_back('{0, 2'b11});
        drive(-2, 0, 12, k);
        total++; if (vq.size() != 0) begin bad++; $display("FAIL ill_sends: got %0d want 0", vq.size()); end
        total++; if (eq.size() != 1 || eq[0] != k + 1) begin bad++; $display("FAIL ill_err: got n=%0d want one at +1", eq.size()); end
        total++; if (dq.size() != 0 || busy_n != 0) begin bad++; $display("FAIL ill_quiet: got done=%0d busy=%0d want 0/0", dq.size(), busy_n); end
        total++; if (cur_res !== model_res) begin bad++; $display("FAIL ill_cur: got %b want %b", cur_res, model_res); end
    endtask

    task automatic test_pending();
        int k, j, d1;
        logic [1:0] s1, s2, s3;
        for (int it = 0; it < 6; it++) begin
            s1 = it == 0 ? 2'b01 : 2'($urandom_range(0, 2));
            s2 = it == 0 ? 2'b10 : 2'($urandom_range(0, 3));
            s3 = it == 0 ? 2'b00 : it == 1 ? 2'b11 : 2'($urandom_range(0, 3));
            j  = $urandom_range(1, 5);
            rqs.delete(); rqs.push_back('{0, s1}); rqs.push_back('{2, s2}); rqs.push_back('{3, s3});
            drive(-2, j, 30, k);
            d1 = k + 4 + j;
            if (s3 != 2'b11) begin
                total++; if (vq.size() != 2 || dq.size() != 2 || eq.size() != 0) begin bad++; $display("FAIL pend_counts: got v%0d d%0d e%0d want 2/2/0", vq.size(), dq.size(), eq.size()); end
                else begin
                    total++; if (vq[0].t != k + 1 || vq[0].d !== {6'b0, s1} || vq[1].t != d1 || vq[1].d !== {6'b0, s3}) begin bad++; $display("FAIL pend_sends: got t%0d d%h, t%0d d%h want t1 d%h, t%0d d%h", vq[0].t - k, vq[0].d, vq[1].t - k, vq[1].d, {6'b0, s1}, d1 - k, {6'b0, s3}); end
                    total++; if (dq[0] != d1 || dq[1] != d1 + 3 + j) begin bad++; $display("FAIL pend_done: got %0d,%0d want %0d,%0d", dq[0] - k, dq[1] - k, d1 - k, d1 + 3 + j - k); end
                end
                model_res = s3;
            end else begin
                total++; if (vq.size() != 1 || dq.size() != 1 || eq.size() != 1) begin bad++; $display("FAIL pend_ill_counts: got v%0d d%0d e%0d want 1/1/1", vq.size(), dq.size(), eq.size()); end
                else begin
                    total++; if (dq[0] != d1 || eq[0] != d1 + 1 || vq[0].d !== {6'b0, s1}) begin bad++; $display("FAIL pend_ill: got done%0d err%0d d%h want %0d,%0d d%h", dq[0] - k, eq[0] - k, vq[0].d, d1 - k, d1 + 1 - k, {6'b0, s1}); end
                end
                model_res = s1;
            end
            total++; if (cur_res !== model_res) begin bad++; $display("FAIL pend_cur: got %b want %b", cur_res, model_res); end
        end
    endtask

    task automatic test_abort();
        int k;
        rqs.delete(); rqs.push_back('{0, 2'b01});
        drive(0, 0, 8, k);
        model_res = 2'b01;
        total++; if (cur_res !== 2'b01) begin bad++; $display("FAIL abort_pre: got %b want 01", cur_res); end
        @(negedge clk); req = 1; res_sel = 2'b10;
        @(negedge clk); req = 0;
        @(negedge clk); req = 1; res_sel = 2'b00;
        @(negedge clk); req = 0;
        #2 rst_n = 0;
        #1;
        total++; if (c_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || c_addr !== 8'h00 || c_data !== 8'h00 || cur_res !== 2'b00) begin bad++; $display("FAIL abort_async: got v%b b%b d%b e%b %h/%h cur%b want all zero", c_valid, busy, done, error, c_addr, c_data, cur_res); end
        model_res = 2'b00;
        @(negedge clk); rst_n = 1;
        vq.delete(); dq.delete(); eq.delete(); busy_n = 0;
        @(negedge clk); c_rdy = 1;
        @(negedge clk); c_rdy = 0;
        repeat (15) @(negedge clk);
        total++; if (vq.size() != 0 || dq.size() != 0 || eq.size() != 0 || busy_n != 0) begin bad++; $display("FAIL abort_quiet: got v%0d d%0d e%0d b%0d want 0000", vq.size(), dq.size(), eq.size(), busy_n); end
        total++; if (cur_res !== 2'b00) begin bad++; $display("FAIL abort_cur: got %b want 00", cur_res); end
    endtask

    task automatic test_boot();
        int r, tv = -1, td = -1, ne = 0;
        logic [7:0] dv = 8'h00, av = 8'h00;
        @(negedge clk); rst_b = 1; r = cyc;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            c_rdy_b = tv >= 0 && cyc == tv + 1;
            if (c_valid_b && tv < 0) begin tv = cyc; dv = c_data_b; av = c_addr_b; end
            if (done_b && td < 0) td = cyc;
            if (error_b) ne++;
        end
        c_rdy_b = 0;
        total++; if (tv < r + 1 || tv > r + 2) begin bad++; $display("FAIL boot_send_time: got %0d want 1..2", tv - r); end
        total++; if (dv !== 8'h02 || av !== 8'h01) begin bad++; $display("FAIL boot_send_data: got %h/%h want 01/02", av, dv); end
        total++; if (td != tv + 3 || ne != 0) begin bad++; $display("FAIL boot_done: got t%0d err%0d want t%0d err0", td - tv, ne, 3); end
        total++; if (cur_res_b !== 2'b10 || busy_b !== 1'b0) begin bad++; $display("FAIL boot_cur: got %b busy%b want 10 busy0", cur_res_b, busy_b); end
    endtask

    initial begin
        #1;
        test_reset();
        test_single();
        test_timeout();
        test_illegal();
        test_pending();
        test_abort();
        test_boot();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_cfg_master.md
Name: vga_cfg_master

Overview:
- Initiator side of the VGA configuration bus. Accepts a resolution request from the system (switch, host or boot default) and issues a single-cycle Valid/Addr/Data write to the VGA_Control config port.
- Waits for the C_rdy (Load_config) acknowledge, with a timeout and retry, and reports Done or Error.
- Holds a one-deep pending-request buffer so requests arriving while busy are not lost.
- Sits between the top-level control logic and VGA_Control.

Parameters:
- CONFIG_WIDTH, 8, width of C_addr and C_data; the value comes from the shared width include.
- ADDR_VGA_CONFIG, 8'h01, config-bus address of the VGA resolution register; the value comes from the shared address include.
- TIMEOUT, 8, cycles spent in WAIT without C_rdy before a retry; legal range 2..255.
- MAX_RETRY, 2, number of re-sends after the first attempt before declaring Error.
- BOOT_RES, 2'b00, resolution to program automatically after reset. 2'b00 means no boot write, because VGA_Control already resets to 640x480.

Ports:
- Clk, input, 1, system clock; all logic is on the rising edge.
- Rst_n, input, 1, asynchronous active-low reset.
- Req, input, 1, request strobe, sampled every cycle.
- Res_sel, input, 2, requested resolution: 00 = 640x480, 01 = 800x600, 10 = 1024x768, 11 = illegal.
- C_rdy, input, 1, acknowledge from VGA_Control (its Load_config).
- C_valid, output, 1, config-bus write strobe.
- C_addr, output, CONFIG_WIDTH, config-bus address.
- C_data, output, CONFIG_WIDTH, config-bus data; Res_sel zero-extended.
- Busy, output, 1, high from request acceptance until the Done or Error pulse.
- Done, output, 1, one-cycle pulse on successful programming.
- Error, output, 1, one-cycle pulse on illegal select or when retries are exhausted.
- Cur_res, output, 2, last successfully programmed resolution.

Behaviour:
- All outputs are registered.
- Reset values: C_valid=0, C_addr=0, C_data=0, Busy=0, Done=0, Error=0, Cur_res=2'b00. The pending buffer is cleared, retry and timeout counters are 0, and the state is IDLE.
- If BOOT_RES != 0, the first cycle after reset release behaves as if Req=1 with Res_sel=BOOT_RES.
- FSM states: IDLE, SEND, WAIT, FIN.
- IDLE:
  - The start source is Req, else the pending buffer if it is valid.
  - Req takes priority over the pending buffer; when Req is taken, the pending entry is discarded.
  - On start with select 11: Error pulses the next cycle, there is no bus activity, and the FSM stays in IDLE.
  - On start with a legal select: latch the select, set Busy=1, go to SEND.
- SEND:
  - C_valid=1 for exactly one cycle.
  - C_addr=ADDR_VGA_CONFIG and C_data={0,sel} during that cycle.
  - Then go to WAIT with the timeout counter at 0.
- Outside SEND, C_valid=0 and C_addr/C_data are driven to 0.
- WAIT:
  - C_rdy=1 → go to FIN with success.
  - Otherwise the counter increments.
  - When the counter reaches TIMEOUT-1 without C_rdy: if retries < MAX_RETRY, increment retries and go to SEND. Otherwise go to FIN with failure.
- FIN:
  - Success: Done=1 and Cur_res <= sel. Failure: Error=1 and Cur_res is unchanged.
  - Busy=0 in the same cycle; retries are cleared.
  - Next state: SEND directly if the pending buffer holds a legal select, consuming it. Otherwise IDLE.
  - A pending 11 is handled through IDLE and produces an Error pulse.
- C_rdy is ignored outside WAIT. This matters because VGA_Control asserts Load_config for one cycle after its own reset.
- Pending buffer: Req while Busy=1 (SEND/WAIT/FIN) sets Pend_vld and stores Res_sel. A later Req overwrites the stored select (latest wins); the depth is 1.
- With no stalls, latency from Req sampled high to Done is 4 cycles: SEND, WAIT (C_rdy arrives on the first WAIT cycle), FIN.
- Re-requesting the current resolution is still sent; there is no skip.
- Rst_n asserted mid-transaction aborts immediately to reset values. There is no Done/Error pulse and the pending request is lost.
- Counter widths are sized by $clog2 of TIMEOUT and MAX_RETRY+1. Retry compare uses unsigned arithmetic with no wrap.

Decomposition:
- Resolution codes (R6X4, R8X6, R10X7, illegal) belong in a shared resolution-code header used by both this block and VGA_Config.
- CONFIG_WIDTH and ADDR_VGA_CONFIG come from the existing shared width and address parameter includes.
- FSM state encodings stay local to this module.
- One natural sub-module: vga_cfg_timer, a loadable timeout counter with a terminal-count flag. It is optional, and a single file is acceptable.

Test Plan:
- Req=1, Res_sel=01 for one cycle; C_rdy one cycle after C_valid → C_valid pulse with C_addr=ADDR_VGA_CONFIG and C_data=8'h01. Done pulses 4 cycles after Req; Cur_res=01; Busy high for 3 cycles.
- Res_sel=10, C_rdy held 0 (TIMEOUT=8, MAX_RETRY=2) → 3 C_valid pulses spaced 9 cycles apart, then a single Error pulse. Cur_res is unchanged and Busy=0 afterwards.
- Req with Res_sel=11 → Error pulse on the next cycle, no C_valid, Busy stays 0.
- During WAIT for 01, apply Req with 10 and then Req with 00 → after Done for 01, SEND starts directly with C_data=00 (latest wins). The 10 is never sent, and 2 Done pulses occur in total.
- Rst_n low during WAIT → all outputs reset asynchronously; after release with BOOT_RES=00, there is no C_valid and the C_rdy pulse from VGA_Control is ignored.
- BOOT_RES=2'b10, release reset → a C_valid with data 10 appears within 2 cycles; the acknowledge produces Done and Cur_res=10.
